// File: rtl/data_mem_responder_pkg.sv
// apex_pkg: definitions shared by the ApexCore data-memory responder.
// Holds the RV32I load/store funct3 encodings and the responder FSM
// state type.
package apex_pkg;

  // Access size and sign, using the RV32I load/store funct3 field
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between the control unit
// (master) and the data-memory responder (slave).
//   request : req_valid / req_ready, wr_en, addr, mem_write, funct3
//   response: resp_valid / resp_ready, mem_read, resp_err
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] mem_write;
  logic [2:0]  funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] mem_read;
  logic        resp_err;

  modport master (
    output req_valid, wr_en, addr, mem_write, funct3, resp_ready,
    input  req_ready, resp_valid, mem_read, resp_err
  );

  modport slave (
    input  req_valid, wr_en, addr, mem_write, funct3, resp_ready,
    output req_ready, resp_valid, mem_read, resp_err
  );
endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// mem_lane_align: combinational RV32I little-endian lane logic.
//   funct3, addr_lo, is_store : access description
//   store_data                : right-aligned store data
//   read_word                 : addressed storage word
//   byte_en, write_word       : lane enables and lane-shifted store word
//   load_data                 : sign/zero-extended load result
//   lane_err                  : misaligned access or illegal funct3
// Every output except lane_err is zero when lane_err is set.
module mem_lane_align
  import apex_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_en,
  output logic [31:0] write_word,
  output logic [31:0] load_data,
  output logic        lane_err
);

  logic [4:0]  shift_s;
  logic [7:0]  rbyte_s;
  logic [15:0] rhalf_s;

  assign shift_s = {addr_lo, 3'b000};
  assign rbyte_s = read_word[shift_s +: 8];
  assign rhalf_s = read_word[{addr_lo[1], 4'b0000} +: 16];

  // Decode size/sign into lane enables, shifted store data and extended load data
  always_comb begin
    byte_en    = 4'b0000;
    write_word = 32'h0000_0000;
    load_data  = 32'h0000_0000;
    lane_err   = 1'b0;
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << addr_lo;
        write_word = {24'h00_0000, store_data[7:0]} << shift_s;
        load_data  = {{24{rbyte_s[7]}}, rbyte_s};
      end
      F3_BU: begin
        // Unsigned forms exist only for loads
        if (is_store) begin
          lane_err = 1'b1;
        end else begin
          load_data = {24'h00_0000, rbyte_s};
        end
      end
      F3_H: begin
        if (addr_lo[0]) begin
          lane_err = 1'b1;
        end else begin
          byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
          write_word = {16'h0000, store_data[15:0]} << shift_s;
          load_data  = {{16{rhalf_s[15]}}, rhalf_s};
        end
      end
      F3_HU: begin
        if (is_store || addr_lo[0]) begin
          lane_err = 1'b1;
        end else begin
          load_data = {16'h0000, rhalf_s};
        end
      end
      F3_W: begin
        if (addr_lo != 2'b00) begin
          lane_err = 1'b1;
        end else begin
          byte_en    = 4'b1111;
          write_word = store_data;
          load_data  = read_word;
        end
      end
      default: begin
        lane_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder for the
// ApexCore datapath with WAIT_CYCLES wait states per access.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of data_mem_responder_if (request + response)
// The access commits (store write / load capture) on the edge that
// enters RESP; errors leave storage untouched and return mem_read = 0.
module data_mem_responder
  import apex_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RANGE_LIMIT = 33'(4 * DEPTH_WORDS);

  dmem_state_t state_r, state_next_s;
  logic [3:0]  cnt_r;
  logic        req_ready_r, resp_valid_r, resp_err_r;
  logic [31:0] mem_read_r;
  logic        wr_en_r;
  logic [31:0] addr_r, wdata_r;
  logic [2:0]  funct3_r;

  logic        accept_s, commit_s;
  logic        acc_wr_en_s;
  logic [31:0] acc_addr_s, acc_wdata_s;
  logic [2:0]  acc_funct3_s;
  logic [32:0] offset_s;
  logic        range_err_s, lane_err_s, err_s;
  logic [IDX_W-1:0] word_idx_s;
  logic [31:0] rdata_s, wword_s, ld_s;
  logic [3:0]  be_s;

  logic [31:0] mem_r [DEPTH_WORDS];

  assign accept_s = (state_r == IDLE) && bus.req_valid && req_ready_r;

  // With zero wait states the access commits on the accept edge, so use the live request in IDLE
  always_comb begin
    if (state_r == IDLE) begin
      acc_wr_en_s  = bus.wr_en;
      acc_addr_s   = bus.addr;
      acc_wdata_s  = bus.mem_write;
      acc_funct3_s = bus.funct3;
    end else begin
      acc_wr_en_s  = wr_en_r;
      acc_addr_s   = addr_r;
      acc_wdata_s  = wdata_r;
      acc_funct3_s = funct3_r;
    end
  end

  // 33-bit difference: an address below BASE_ADDR sets bit 32 and so also fails the limit compare
  assign offset_s    = {1'b0, acc_addr_s} - {1'b0, BASE_ADDR};
  assign range_err_s = (offset_s >= RANGE_LIMIT);
  assign word_idx_s  = range_err_s ? {IDX_W{1'b0}} : offset_s[IDX_W+1:2];
  assign rdata_s     = mem_r[word_idx_s];
  assign err_s       = lane_err_s | range_err_s;

  mem_lane_align u_lane_align (
    .funct3     (acc_funct3_s),
    .addr_lo    (acc_addr_s[1:0]),
    .is_store   (acc_wr_en_s),
    .store_data (acc_wdata_s),
    .read_word  (rdata_s),
    .byte_en    (be_s),
    .write_word (wword_s),
    .load_data  (ld_s),
    .lane_err   (lane_err_s)
  );

  // Next-state logic; commit_s marks the edge that enters RESP
  always_comb begin
    state_next_s = state_r;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (WAIT_CYCLES == 0) begin
            state_next_s = RESP;
            commit_s     = 1'b1;
          end else begin
            state_next_s = WAIT;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = RESP;
          commit_s     = 1'b1;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, wait counter, request latch and registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      mem_read_r   <= 32'h0000_0000;
      wr_en_r      <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      funct3_r     <= 3'b000;
    end else begin
      state_r      <= state_next_s;
      req_ready_r  <= (state_next_s == IDLE);
      resp_valid_r <= (state_next_s == RESP);
      if (accept_s) begin
        wr_en_r  <= bus.wr_en;
        addr_r   <= bus.addr;
        wdata_r  <= bus.mem_write;
        funct3_r <= bus.funct3;
        cnt_r    <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (commit_s) begin
        mem_read_r <= (err_s || acc_wr_en_s) ? 32'h0000_0000 : ld_s;
        resp_err_r <= err_s;
      end else if ((state_r == RESP) && bus.resp_ready) begin
        mem_read_r <= 32'h0000_0000;
        resp_err_r <= 1'b0;
      end
    end
  end

  // Storage write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (commit_s && acc_wr_en_s && !err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[word_idx_s][8*b +: 8] <= wword_s[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.mem_read   = mem_read_r;
  assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed bench for data_mem_responder.
// Three instances (WAIT_CYCLES = 1, 0, 3) share one set of request
// drivers; sel_v picks which instance gets req_valid and is observed.
module tb_data_mem_responder;
  import apex_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          sel_v = 0;
  logic        req_valid_v = 1'b0;
  logic        wr_en_v = 1'b0;
  logic        resp_ready_v = 1'b1;
  logic [31:0] addr_v = 32'h0;
  logic [31:0] mdata_v = 32'h0;
  logic [2:0]  f3_v = 3'b000;

  data_mem_responder_if bus1 ();
  data_mem_responder_if bus0 ();
  data_mem_responder_if bus3 ();

  assign bus1.req_valid  = req_valid_v && (sel_v == 0);
  assign bus0.req_valid  = req_valid_v && (sel_v == 1);
  assign bus3.req_valid  = req_valid_v && (sel_v == 2);
  assign bus1.wr_en      = wr_en_v;
  assign bus0.wr_en      = wr_en_v;
  assign bus3.wr_en      = wr_en_v;
  assign bus1.addr       = addr_v;
  assign bus0.addr       = addr_v;
  assign bus3.addr       = addr_v;
  assign bus1.mem_write  = mdata_v;
  assign bus0.mem_write  = mdata_v;
  assign bus3.mem_write  = mdata_v;
  assign bus1.funct3     = f3_v;
  assign bus0.funct3     = f3_v;
  assign bus3.funct3     = f3_v;
  assign bus1.resp_ready = resp_ready_v;
  assign bus0.resp_ready = resp_ready_v;
  assign bus3.resp_ready = resp_ready_v;

  data_mem_responder #(.WAIT_CYCLES(1)) u_dut    (.clk(clk), .rst(rst), .bus(bus1));
  data_mem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (.clk(clk), .rst(rst), .bus(bus0));
  data_mem_responder #(.WAIT_CYCLES(3)) u_dut_w3 (.clk(clk), .rst(rst), .bus(bus3));

  // {req_ready, resp_valid, resp_err, mem_read} of the selected instance
  function automatic logic [34:0] obs();
    case (sel_v)
      0:       return {bus1.req_ready, bus1.resp_valid, bus1.resp_err, bus1.mem_read};
      1:       return {bus0.req_ready, bus0.resp_valid, bus0.resp_err, bus0.mem_read};
      default: return {bus3.req_ready, bus3.resp_valid, bus3.resp_err, bus3.mem_read};
    endcase
  endfunction

  // One access with resp_ready high. lat = clock edges from the accept edge
  // up to and including the edge at which the requester sees resp_valid.
  task automatic access(input int sel, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    logic [34:0] o;
    sel_v = sel;
    guard = 0;
    o = obs();
    while (!o[34] && guard < 40) begin
      @(posedge clk); #1; guard++; o = obs();
    end
    if (!o[34]) begin
      tests++; fails++;
      $display("FAIL req_ready_timeout actual=0 required=1");
    end
    wr_en_v = wr; addr_v = a; mdata_v = d; f3_v = f3;
    req_valid_v = 1'b1; resp_ready_v = 1'b1;
    @(posedge clk); #1;
    req_valid_v = 1'b0;
    lat = 0;
    o = obs();
    while (!o[33] && lat < 40) begin
      @(posedge clk); #1; lat++; o = obs();
    end
    if (!o[33]) begin
      tests++; fails++;
      $display("FAIL resp_valid_timeout actual=0 required=1");
    end
    lat = lat + 1;
    rd = o[31:0];
    er = o[32];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [34:0] o;
    #2;
    o = obs();
    tests++;
    if (o !== 35'd0) begin
      fails++; $display("FAIL reset_outputs actual=%h required=%h", o, 35'd0);
    end
    @(negedge clk); rst = 1'b0; #1;
    o = obs();
    tests++;
    if (o[34] !== 1'b0) begin
      fails++; $display("FAIL ready_before_edge actual=%b required=0", o[34]);
    end
    @(posedge clk); #1;
    o = obs();
    tests++;
    if (o[34] !== 1'b1) begin
      fails++; $display("FAIL ready_after_edge actual=%b required=1", o[34]);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, F3_W, rd, er, lat);
    tests++;
    if ({er, rd} !== {1'b0, 32'h0} || lat != 2) begin
      fails++; $display("FAIL sw_word actual=%b/%h/%0d required=0/00000000/2", er, rd, lat);
    end
    access(0, 1'b0, 32'h10, 32'h0, F3_W, rd, er, lat);
    tests++;
    if ({er, rd} !== {1'b0, 32'hDEAD_BEEF} || lat != 2) begin
      fails++; $display("FAIL lw_word actual=%b/%h/%0d required=0/deadbeef/2", er, rd, lat);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_v [6];
    logic [2:0]  f3_t  [6];
    logic [31:0] a_t   [6];
    logic [31:0] d_t   [6];
    logic        wr_t  [6];
    // SB 0x13, LW 0x10, LB 0x13, LBU 0x13, SH 0x12, LH 0x12
    wr_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    f3_t = '{F3_B, F3_W, F3_B, F3_BU, F3_H, F3_H};
    a_t  = '{32'h13, 32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
    d_t  = '{32'h80, 32'h0, 32'h0, 32'h0, 32'h1234, 32'h0};
    exp_v = '{32'h0, 32'h80AD_BEEF, 32'hFFFF_FF80, 32'h0000_0080, 32'h0, 32'h0000_1234};
    for (int i = 0; i < 6; i++) begin
      access(0, wr_t[i], a_t[i], d_t[i], f3_t[i], rd, er, lat);
      tests++;
      if ({er, rd} !== {1'b0, exp_v[i]}) begin
        fails++; $display("FAIL lane_%0d actual=%b/%h required=0/%h", i, er, rd, exp_v[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    access(0, 1'b0, 32'h11, 32'h0, F3_W, rd, er, lat);
    tests++;
    if ({er, rd} !== {1'b1, 32'h0} || lat != 2) begin
      fails++; $display("FAIL lw_misaligned actual=%b/%h/%0d required=1/00000000/2", er, rd, lat);
    end
    access(0, 1'b1, 32'h14, 32'hCAFE_F00D, F3_W, rd, er, lat);
    access(0, 1'b1, 32'h15, 32'h5555, F3_H, rd, er, lat);
    tests++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      fails++; $display("FAIL sh_misaligned actual=%b/%h required=1/00000000", er, rd);
    end
    access(0, 1'b1, 32'h14, 32'h77, F3_BU, rd, er, lat);
    tests++;
    if (er !== 1'b1) begin
      fails++; $display("FAIL store_f3_100 actual=%b required=1", er);
    end
    access(0, 1'b0, 32'h14, 32'h0, F3_W, rd, er, lat);
    tests++;
    if ({er, rd} !== {1'b0, 32'hCAFE_F00D}) begin
      fails++; $display("FAIL word_unchanged actual=%b/%h required=0/cafef00d", er, rd);
    end
    access(0, 1'b0, 32'h14, 32'h0, 3'b011, rd, er, lat);
    tests++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      fails++; $display("FAIL load_f3_011 actual=%b/%h required=1/00000000", er, rd);
    end
    access(0, 1'b0, 32'h1000, 32'h0, F3_W, rd, er, lat);
    tests++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      fails++; $display("FAIL lw_out_of_range actual=%b/%h required=1/00000000", er, rd);
    end
    access(0, 1'b0, 32'hFFC, 32'h0, F3_W, rd, er, lat);
    tests++;
    if (er !== 1'b0) begin
      fails++; $display("FAIL lw_last_word actual=%b required=0", er);
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] o;
    int guard;
    sel_v = 0;
    wr_en_v = 1'b0; addr_v = 32'h10; f3_v = F3_W;
    req_valid_v = 1'b1; resp_ready_v = 1'b0;
    @(posedge clk); #1;
    req_valid_v = 1'b0;
    guard = 0;
    o = obs();
    while (!o[33] && guard < 40) begin
      @(posedge clk); #1; guard++; o = obs();
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      o = obs();
      tests++;
      if (o !== {1'b0, 1'b1, 1'b0, 32'h1234_BEEF}) begin
        fails++; $display("FAIL hold_cycle_%0d actual=%h required=%h", i, o, {1'b0, 1'b1, 1'b0, 32'h1234_BEEF});
      end
    end
    resp_ready_v = 1'b1;
    @(posedge clk); #1;
    o = obs();
    tests++;
    if (o[34:33] !== 2'b10) begin
      fails++; $display("FAIL ready_after_handshake actual=%b required=10", o[34:33]);
    end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic er; int lat;
    access(1, 1'b1, 32'h40, 32'hA5A5_0001, F3_W, rd, er, lat);
    tests++;
    if (lat != 1) begin
      fails++; $display("FAIL latency_w0 actual=%0d required=1", lat);
    end
    access(1, 1'b0, 32'h40, 32'h0, F3_W, rd, er, lat);
    tests++;
    if (rd !== 32'hA5A5_0001 || lat != 1) begin
      fails++; $display("FAIL load_w0 actual=%h/%0d required=a5a50001/1", rd, lat);
    end
    access(2, 1'b1, 32'h40, 32'h0BAD_CAFE, F3_W, rd, er, lat);
    tests++;
    if (lat != 4) begin
      fails++; $display("FAIL latency_w3 actual=%0d required=4", lat);
    end
    access(2, 1'b0, 32'h40, 32'h0, F3_W, rd, er, lat);
    tests++;
    if (rd !== 32'h0BAD_CAFE || lat != 4) begin
      fails++; $display("FAIL load_w3 actual=%h/%0d required=0badcafe/4", rd, lat);
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd; logic er; int lat;
    logic [34:0] o;
    access(0, 1'b1, 32'h20, 32'h2222_2222, F3_W, rd, er, lat);
    sel_v = 0;
    wr_en_v = 1'b1; addr_v = 32'h20; mdata_v = 32'h1111_1111; f3_v = F3_W;
    req_valid_v = 1'b1; resp_ready_v = 1'b1;
    @(posedge clk); #1;
    req_valid_v = 1'b0;
    rst = 1'b1;
    #1;
    o = obs();
    tests++;
    if (o !== 35'd0) begin
      fails++; $display("FAIL reset_in_wait actual=%h required=%h", o, 35'd0);
    end
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; #1;
    o = obs();
    tests++;
    if (o[34] !== 1'b0) begin
      fails++; $display("FAIL ready_low_after_deassert actual=%b required=0", o[34]);
    end
    @(posedge clk); #1;
    o = obs();
    tests++;
    if (o[34] !== 1'b1) begin
      fails++; $display("FAIL ready_high_after_edge actual=%b required=1", o[34]);
    end
    access(0, 1'b0, 32'h20, 32'h0, F3_W, rd, er, lat);
    tests++;
    if ({er, rd} !== {1'b0, 32'h2222_2222}) begin
      fails++; $display("FAIL store_discarded actual=%b/%h required=0/22222222", er, rd);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_backpressure();
    test_latency();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
